// File: rtl/i2c_cmd_sequencer_pkg.sv
// Shared types and constants for the table-driven I2C command sequencer.
// Holds the master mode codes, the ROM entry layout and the MPU6050 register map.
package i2c_seq_pkg;

    localparam logic [7:0] MODE_WAIT         = 8'h00;
    localparam logic [7:0] MODE_SINGLE_WRITE = 8'h01;
    localparam logic [7:0] MODE_CONT_WRITE   = 8'h02;
    localparam logic [7:0] MODE_WRITE_DIRECT = 8'h03;
    localparam logic [7:0] MODE_SINGLE_READ  = 8'h04;
    localparam logic [7:0] MODE_CONT_READ    = 8'h05;
    localparam logic [7:0] MODE_READ_DIRECT  = 8'h06;

    localparam logic [7:0] REG_SMPLRT_DIV    = 8'h19;
    localparam logic [7:0] REG_CONFIG        = 8'h1A;
    localparam logic [7:0] REG_GYRO_CONFIG   = 8'h1B;
    localparam logic [7:0] REG_ACCEL_CONFIG  = 8'h1C;
    localparam logic [7:0] REG_ACCEL_XOUT_H  = 8'h3B;
    localparam logic [7:0] REG_PWR_MGMT_1    = 8'h6B;

    typedef struct packed {
        logic [7:0] mode;
        logic [7:0] reg_addr;
        logic [7:0] reg_data;
    } cmd_entry_t;

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_GAP
    } seq_state_e;

    // Modes whose completion returns a byte that belongs in the read bank.
    function automatic logic is_read(input logic [7:0] mode);
        return (mode == MODE_SINGLE_READ) || (mode == MODE_CONT_READ) ||
               (mode == MODE_READ_DIRECT);
    endfunction

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// Command/response bus between the sequencer and i2c_master_logic.
interface i2c_cmd_sequencer_if;
    logic       i2c_done;
    logic [7:0] i2c_read_data;
    logic [7:0] i2c_config;
    logic [6:0] i2c_dev_addr;
    logic [7:0] i2c_reg_addr;
    logic [7:0] i2c_reg_data;

    modport master (
        output i2c_config, i2c_dev_addr, i2c_reg_addr, i2c_reg_data,
        input  i2c_done, i2c_read_data
    );

    modport slave (
        input  i2c_config, i2c_dev_addr, i2c_reg_addr, i2c_reg_data,
        output i2c_done, i2c_read_data
    );
endinterface

// File: rtl/i2c_cmd_rom.sv
// Command table for the MPU6050: init writes followed by single-byte poll reads.
// A different device is supported by replacing only this module.
module i2c_cmd_rom
    import i2c_seq_pkg::*;
#(
    parameter  int unsigned NUM_INIT = 5,
    parameter  int unsigned NUM_POLL = 14,
    localparam int unsigned IDX_W    = $clog2(NUM_INIT + NUM_POLL)
) (
    input  logic [IDX_W-1:0] cmd_index,
    output cmd_entry_t       entry_c
);

    logic [IDX_W-1:0] poll_k;

    always_comb begin
        entry_c = '0;
        poll_k  = cmd_index - IDX_W'(NUM_INIT);
        if (32'(cmd_index) < NUM_INIT) begin
            case (32'(cmd_index))
                32'd0:   entry_c = {MODE_SINGLE_WRITE, REG_PWR_MGMT_1,   8'h00};
                32'd1:   entry_c = {MODE_SINGLE_WRITE, REG_SMPLRT_DIV,   8'h07};
                32'd2:   entry_c = {MODE_SINGLE_WRITE, REG_CONFIG,       8'h06};
                32'd3:   entry_c = {MODE_SINGLE_WRITE, REG_GYRO_CONFIG,  8'h18};
                32'd4:   entry_c = {MODE_SINGLE_WRITE, REG_ACCEL_CONFIG, 8'h01};
                default: entry_c = '0;
            endcase
        end else if (32'(cmd_index) < NUM_INIT + NUM_POLL) begin
            // Poll k reads the k-th consecutive register from ACCEL_XOUT_H.
            entry_c = {MODE_SINGLE_READ, REG_ACCEL_XOUT_H + 8'(poll_k), 8'h00};
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Table-driven I2C sequencer: one-shot init list, then a periodic poll list,
// with done synchronisation, per-command timeout/retry and inter-command gaps.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter  logic [6:0]  DEV_ADDR       = 7'h68,
    parameter  int unsigned NUM_INIT       = 5,
    parameter  int unsigned NUM_POLL       = 14,
    parameter  int unsigned STARTUP_CYCLES = 1200000,
    parameter  int unsigned GAP_CYCLES     = 240,
    parameter  int unsigned TIMEOUT_CYCLES = 120000,
    parameter  int unsigned MAX_RETRY      = 3,
    parameter  int unsigned FRAME_CYCLES   = 120000,
    localparam int unsigned IDX_W          = $clog2(NUM_INIT + NUM_POLL)
) (
    input  logic                   clk_12m,
    input  logic                   rst_n,
    input  logic                   enable,
    i2c_cmd_sequencer_if.master    bus,
    output logic [8*NUM_POLL-1:0]  rd_data_bus,
    output logic                   frame_valid,
    output logic                   init_done,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [IDX_W-1:0]       cmd_index
);

    localparam int unsigned CNT_MAX0 = (STARTUP_CYCLES > TIMEOUT_CYCLES) ? STARTUP_CYCLES
                                                                          : TIMEOUT_CYCLES;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > GAP_CYCLES) ? CNT_MAX0 : GAP_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned FRAME_W  = $clog2(FRAME_CYCLES + 1);
    localparam int unsigned RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    seq_state_e           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 ok_q, ok_d;
    logic [7:0]           cfg_q, cfg_d;
    logic [6:0]           dev_q, dev_d;
    logic [7:0]           reg_q, reg_d;
    logic [7:0]           dat_q, dat_d;
    logic [8*NUM_POLL-1:0] bank_q, bank_d;
    logic                 fv_q, fv_d;
    logic                 init_done_q, init_done_d;
    logic                 busy_q, busy_d;
    logic                 terr_q, terr_d;
    logic                 sync1_q, sync2_q, sync3_q;
    logic                 done_evt;
    logic                 frame_start;
    cmd_entry_t           entry_c;

    i2c_cmd_rom #(
        .NUM_INIT (NUM_INIT),
        .NUM_POLL (NUM_POLL)
    ) u_rom (
        .cmd_index (idx_q),
        .entry_c   (entry_c)
    );

    // i2c_done comes from the i2c_clk domain: two-flop synchroniser plus edge detect.
    assign done_evt    = sync2_q & ~sync3_q;
    assign frame_start = (idx_q == IDX_W'(NUM_INIT));

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_STARTUP;
            idx_q       <= '0;
            retry_q     <= '0;
            cnt_q       <= '0;
            frame_q     <= '0;
            ok_q        <= 1'b0;
            cfg_q       <= '0;
            dev_q       <= '0;
            reg_q       <= '0;
            dat_q       <= '0;
            bank_q      <= '0;
            fv_q        <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
            terr_q      <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            ok_q        <= ok_d;
            cfg_q       <= cfg_d;
            dev_q       <= dev_d;
            reg_q       <= reg_d;
            dat_q       <= dat_d;
            bank_q      <= bank_d;
            fv_q        <= fv_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            terr_q      <= terr_d;
            sync1_q     <= bus.i2c_done;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        cnt_d       = cnt_q;
        ok_d        = ok_q;
        frame_d     = (frame_q == FRAME_W'(FRAME_CYCLES)) ? frame_q : frame_q + FRAME_W'(1);
        cfg_d       = cfg_q;
        dev_d       = dev_q;
        reg_d       = reg_q;
        dat_d       = dat_q;
        bank_d      = bank_q;
        fv_d        = 1'b0;
        init_done_d = init_done_q;
        busy_d      = busy_q;
        terr_d      = terr_q;

        case (state_q)
            ST_STARTUP: begin
                if (cnt_q == CNT_W'(STARTUP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_IDLE: begin
                // The first poll entry also waits for the frame period to elapse.
                if (enable && (!frame_start || (frame_q >= FRAME_W'(FRAME_CYCLES)))) begin
                    state_d = ST_ISSUE;
                    cfg_d   = entry_c.mode;
                    dev_d   = DEV_ADDR;
                    reg_d   = entry_c.reg_addr;
                    dat_d   = entry_c.reg_data;
                    busy_d  = 1'b1;
                    if (frame_start) begin
                        frame_d = '0;
                    end
                end
            end

            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (done_evt) begin
                    ok_d    = 1'b1;
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    cfg_d   = MODE_WAIT;
                    if (is_read(cfg_q)) begin
                        for (int unsigned k = 0; k < NUM_POLL; k++) begin
                            if (32'(idx_q) == NUM_INIT + k) begin
                                bank_d[8*k +: 8] = bus.i2c_read_data;
                            end
                        end
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    ok_d    = 1'b0;
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    cfg_d   = MODE_WAIT;
                end
            end

            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    if (!ok_q && (retry_q != RETRY_W'(MAX_RETRY))) begin
                        retry_d = retry_q + RETRY_W'(1);
                    end else begin
                        retry_d = '0;
                        if (!ok_q) begin
                            terr_d = 1'b1;
                        end
                        if (idx_q == IDX_W'(NUM_INIT - 1)) begin
                            init_done_d = 1'b1;
                        end
                        if (idx_q == IDX_W'(NUM_INIT + NUM_POLL - 1)) begin
                            idx_d = IDX_W'(NUM_INIT);
                            fv_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = ST_STARTUP;
        endcase
    end

    assign bus.i2c_config   = cfg_q;
    assign bus.i2c_dev_addr = dev_q;
    assign bus.i2c_reg_addr = reg_q;
    assign bus.i2c_reg_data = dat_q;
    assign rd_data_bus      = bank_q;
    assign frame_valid      = fv_q;
    assign init_done        = init_done_q;
    assign busy             = busy_q;
    assign timeout_err      = terr_q;
    assign cmd_index        = idx_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with shortened timing parameters and a
// simple master model that answers each command after a fixed delay.
module tb_i2c_cmd_sequencer;

    localparam int NI      = 5;
    localparam int NP      = 14;
    localparam int NT      = NI + NP;
    localparam int STARTUP = 60;
    localparam int GAP     = 4;
    localparam int TMO     = 100;
    localparam int RETRY   = 3;
    localparam int FRAME   = 800;
    localparam int BFM_DLY = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [8*NP-1:0] rd_data_bus;
    logic          frame_valid;
    logic          init_done;
    logic          busy;
    logic          timeout_err;
    logic [4:0]    cmd_index;

    i2c_cmd_sequencer_if bus ();

    i2c_cmd_sequencer #(
        .DEV_ADDR       (7'h68),
        .NUM_INIT       (NI),
        .NUM_POLL       (NP),
        .STARTUP_CYCLES (STARTUP),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRY      (RETRY),
        .FRAME_CYCLES   (FRAME)
    ) dut (
        .clk_12m     (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .bus         (bus),
        .rd_data_bus (rd_data_bus),
        .frame_valid (frame_valid),
        .init_done   (init_done),
        .busy        (busy),
        .timeout_err (timeout_err),
        .cmd_index   (cmd_index)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rel_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Master model state and per-entry logs
    int         drop_idx  = -1;
    int         drop_left = 0;
    logic [7:0] data_base = 8'h3B;
    int         attempts  [NT];
    logic [7:0] log_cfg   [NT];
    logic [7:0] log_reg   [NT];
    logic [7:0] log_dat   [NT];
    logic [6:0] log_dev   [NT];
    logic       log_idn   [NT];
    int         last_len  [NT];
    int         start_cyc [NT];
    int         end_cyc   [NT];
    int         frame_starts[$];
    int         fv_count  = 0;
    bit         fv_double = 1'b0;
    bit         fv_prev   = 1'b0;
    bit         active    = 1'b0;
    int         bfm_cnt   = 0;
    int         cur_idx   = 0;

    logic [7:0] exp_reg [NI] = '{8'h6B, 8'h19, 8'h1A, 8'h1B, 8'h1C};
    logic [7:0] exp_dat [NI] = '{8'h00, 8'h07, 8'h06, 8'h18, 8'h01};

    // Master model: raises done BFM_DLY cycles after a command appears, drops it on config 00.
    initial begin
        bus.i2c_done      = 1'b0;
        bus.i2c_read_data = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.i2c_config == 8'h00) begin
                if (active) begin
                    last_len[cur_idx] = bfm_cnt;
                    end_cyc[cur_idx]  = cyc;
                    if (!bus.i2c_done && cur_idx == drop_idx && drop_left > 0) drop_left--;
                end
                active       = 1'b0;
                bfm_cnt      = 0;
                bus.i2c_done = 1'b0;
            end else begin
                if (!active) begin
                    active  = 1'b1;
                    cur_idx = int'(cmd_index);
                    if (cur_idx >= NT) cur_idx = NT - 1;
                    attempts[cur_idx]++;
                    log_cfg[cur_idx]   = bus.i2c_config;
                    log_reg[cur_idx]   = bus.i2c_reg_addr;
                    log_dat[cur_idx]   = bus.i2c_reg_data;
                    log_dev[cur_idx]   = bus.i2c_dev_addr;
                    log_idn[cur_idx]   = init_done;
                    start_cyc[cur_idx] = cyc;
                    if (cur_idx == NI) frame_starts.push_back(cyc);
                end
                bfm_cnt++;
                if (bfm_cnt >= BFM_DLY && !(cur_idx == drop_idx && drop_left > 0)) begin
                    bus.i2c_read_data = 8'(int'(data_base) + cur_idx - NI);
                    bus.i2c_done      = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (frame_valid) fv_count++;
        if (frame_valid && fv_prev) fv_double = 1'b1;
        fv_prev = frame_valid;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        for (int i = 0; i < NT; i++) begin
            attempts[i]  = 0;
            last_len[i]  = 0;
            start_cyc[i] = 0;
            end_cyc[i]   = 0;
            log_cfg[i]   = '0;
            log_reg[i]   = '0;
            log_dat[i]   = '0;
            log_dev[i]   = '0;
            log_idn[i]   = 1'b0;
        end
        frame_starts.delete();
        fv_count  = 0;
        fv_double = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (5) @(negedge clk);
        clear_logs();
        rst_n   = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic wait_index(input int idx, input int lim, input string name);
        int n = 0;
        while (int'(cmd_index) != idx && n < lim) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (int'(cmd_index) != idx) begin
            errors++;
            $display("FAIL %s: cmd_index=%0d required %0d within %0d cycles", name, cmd_index, idx, lim);
        end
    endtask

    task automatic wait_issue(input int lim, input string name);
        int n = 0;
        while (bus.i2c_config == 8'h00 && n < lim) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.i2c_config == 8'h00) begin
            errors++;
            $display("FAIL %s: no command issued within %0d cycles", name, lim);
        end
    endtask

    task automatic wait_frame(input int lim, input string name);
        int n = 0;
        while (frame_valid !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: no frame_valid within %0d cycles", name, lim);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.i2c_config, bus.i2c_dev_addr, bus.i2c_reg_addr, bus.i2c_reg_data} !== 31'h0) begin
            errors++;
            $display("FAIL reset_bus: got %h required 0",
                     {bus.i2c_config, bus.i2c_dev_addr, bus.i2c_reg_addr, bus.i2c_reg_data});
        end
        checks++;
        if ({frame_valid, init_done, busy, timeout_err, cmd_index} !== 9'h0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0",
                     {frame_valid, init_done, busy, timeout_err, cmd_index});
        end
        checks++;
        if (rd_data_bus !== '0) begin
            errors++;
            $display("FAIL reset_bank: got %h required 0", rd_data_bus);
        end
        clear_logs();
        rst_n   = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic test_init();
        wait_index(NI, 600, "init_complete");
        checks++;
        if (start_cyc[0] - rel_cyc != STARTUP + 1) begin
            errors++;
            $display("FAIL startup_delay: got %0d required %0d", start_cyc[0] - rel_cyc, STARTUP + 1);
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({log_cfg[i], log_reg[i], log_dat[i]} !== {8'h01, exp_reg[i], exp_dat[i]}
                || attempts[i] != 1) begin
                errors++;
                $display("FAIL init_entry%0d: got cfg=%h reg=%h dat=%h n=%0d required 01/%h/%h n=1",
                         i, log_cfg[i], log_reg[i], log_dat[i], attempts[i], exp_reg[i], exp_dat[i]);
            end
        end
        checks++;
        if (log_dev[0] !== 7'h68) begin
            errors++;
            $display("FAIL dev_addr: got %h required 68", log_dev[0]);
        end
        checks++;
        if (last_len[0] != BFM_DLY + 2) begin
            errors++;
            $display("FAIL done_latency: got %0d required %0d", last_len[0], BFM_DLY + 2);
        end
        checks++;
        if (start_cyc[1] - end_cyc[0] != GAP + 1) begin
            errors++;
            $display("FAIL gap_length: got %0d required %0d", start_cyc[1] - end_cyc[0], GAP + 1);
        end
        checks++;
        if (log_idn[4] !== 1'b0 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_done: at entry4 issue=%b after=%b required 0/1", log_idn[4], init_done);
        end
    endtask

    task automatic test_poll();
        wait_frame(2000, "poll_frame1");
        checks++;
        if (rd_data_bus[7:0] !== 8'h3B || rd_data_bus[47:40] !== 8'h40 || rd_data_bus[111:104] !== 8'h48) begin
            errors++;
            $display("FAIL poll_bytes: got b0=%h b5=%h b13=%h required 3B/40/48",
                     rd_data_bus[7:0], rd_data_bus[47:40], rd_data_bus[111:104]);
        end
        checks++;
        if (log_reg[NI + 13] !== 8'h48 || log_cfg[NI + 13] !== 8'h04) begin
            errors++;
            $display("FAIL poll_cmd: got cfg=%h reg=%h required 04/48", log_cfg[NI + 13], log_reg[NI + 13]);
        end
        @(negedge clk);
        wait_frame(2000, "poll_frame2");
        @(negedge clk);
        checks++;
        if (fv_count != 2 || fv_double) begin
            errors++;
            $display("FAIL frame_pulses: got count=%0d double=%0b required 2/0", fv_count, fv_double);
        end
        checks++;
        if (frame_starts.size() < 2 || frame_starts[1] - frame_starts[0] < FRAME) begin
            errors++;
            $display("FAIL frame_period: got starts=%0d spacing=%0d required >=%0d",
                     frame_starts.size(), frame_starts.size() >= 2 ? frame_starts[1] - frame_starts[0] : 0, FRAME);
        end
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL poll_no_timeout: got %b required 0", timeout_err);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        drop_idx  = 2;
        drop_left = 100;
        wait_index(3, 1500, "timeout_skip");
        checks++;
        if (attempts[2] != RETRY + 1 || last_len[2] != TMO + 1) begin
            errors++;
            $display("FAIL timeout_attempts: got n=%0d len=%0d required %0d/%0d",
                     attempts[2], last_len[2], RETRY + 1, TMO + 1);
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err_set: got %b required 1", timeout_err);
        end
        wait_index(NI, 400, "timeout_init_end");
        checks++;
        if (attempts[2] != RETRY + 1 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL timeout_no_rerun: got n=%0d init_done=%b required %0d/1",
                     attempts[2], init_done, RETRY + 1);
        end
        drop_idx  = -1;
        drop_left = 0;
    endtask

    task automatic test_retry();
        apply_reset();
        drop_idx  = NI + 5;
        drop_left = 2;
        data_base = 8'h80;
        wait_frame(3000, "retry_frame");
        checks++;
        if (attempts[NI + 5] != 3 || last_len[NI + 5] != BFM_DLY + 2) begin
            errors++;
            $display("FAIL retry_attempts: got n=%0d len=%0d required 3/%0d",
                     attempts[NI + 5], last_len[NI + 5], BFM_DLY + 2);
        end
        checks++;
        if (rd_data_bus[47:40] !== 8'h85 || rd_data_bus[7:0] !== 8'h80) begin
            errors++;
            $display("FAIL retry_bytes: got b5=%h b0=%h required 85/80", rd_data_bus[47:40], rd_data_bus[7:0]);
        end
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL retry_timeout_err: got %b required 0", timeout_err);
        end
        drop_idx  = -1;
        drop_left = 0;
    endtask

    task automatic test_enable();
        int n = 0;
        int att9;
        data_base = 8'h90;
        while (!(int'(cmd_index) == NI + 3 && bus.i2c_config != 8'h00) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(int'(cmd_index) == NI + 3 && bus.i2c_config != 8'h00)) begin
            errors++;
            $display("FAIL enable_reach_poll3: cmd_index=%0d config=%h required %0d/nonzero",
                     cmd_index, bus.i2c_config, NI + 3);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_wait: got %b required 1", busy);
        end
        att9   = attempts[NI + 4];
        enable = 1'b0;
        wait_index(NI + 4, 200, "enable_finish_cmd");
        repeat (60) @(negedge clk);
        checks++;
        if (bus.i2c_config !== 8'h00 || busy !== 1'b0 || int'(cmd_index) != NI + 4 || attempts[NI + 4] != att9) begin
            errors++;
            $display("FAIL enable_park: got cfg=%h busy=%b idx=%0d n=%0d required 00/0/%0d/%0d",
                     bus.i2c_config, busy, cmd_index, attempts[NI + 4], NI + 4, att9);
        end
        checks++;
        if (rd_data_bus[31:24] !== 8'h93) begin
            errors++;
            $display("FAIL enable_byte3: got %h required 93", rd_data_bus[31:24]);
        end
        enable = 1'b1;
        wait_issue(50, "enable_resume");
        checks++;
        if (int'(cmd_index) != NI + 4 || bus.i2c_reg_addr !== 8'h3F || bus.i2c_config !== 8'h04) begin
            errors++;
            $display("FAIL enable_resume_cmd: got idx=%0d reg=%h cfg=%h required %0d/3F/04",
                     cmd_index, bus.i2c_reg_addr, bus.i2c_config, NI + 4);
        end
    endtask

    task automatic test_reset_mid();
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.i2c_config, bus.i2c_dev_addr, bus.i2c_reg_addr, bus.i2c_reg_data} !== 31'h0) begin
            errors++;
            $display("FAIL midreset_bus: got %h required 0",
                     {bus.i2c_config, bus.i2c_dev_addr, bus.i2c_reg_addr, bus.i2c_reg_data});
        end
        checks++;
        if ({frame_valid, init_done, busy, timeout_err, cmd_index} !== 9'h0 || rd_data_bus !== '0) begin
            errors++;
            $display("FAIL midreset_state: got flags=%b bank=%h required 0",
                     {frame_valid, init_done, busy, timeout_err, cmd_index}, rd_data_bus);
        end
        repeat (3) @(negedge clk);
        clear_logs();
        rst_n   = 1'b1;
        rel_cyc = cyc;
        wait_issue(200, "midreset_restart");
        checks++;
        if (int'(cmd_index) != 0 || bus.i2c_config !== 8'h01 || bus.i2c_reg_addr !== 8'h6B
            || init_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_entry0: got idx=%0d cfg=%h reg=%h init_done=%b required 0/01/6B/0",
                     cmd_index, bus.i2c_config, bus.i2c_reg_addr, init_done);
        end
        @(negedge clk);
        checks++;
        if (start_cyc[0] - rel_cyc != STARTUP + 1) begin
            errors++;
            $display("FAIL midreset_startup: got %0d required %0d", start_cyc[0] - rel_cyc, STARTUP + 1);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_poll();
        test_timeout();
        test_retry();
        test_enable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
- Table-driven successor to the fixed 3-state I2C config sequencer; runs entirely in the clk_12m domain and feeds i2c_master_logic.
- Runs a one-shot init list, then loops a poll list forever; configured for MPU6050 by default.
- Read bytes land in a flattened bank; a frame_valid strobe marks each complete frame.
- Adds timeout/retry, inter-command gaps and a programmable frame period. The old block clocked its state on posedge of i2c_done; this one does not.

Parameters:
- DEV_ADDR, 7'h68, 7-bit slave address applied to every command.
- NUM_INIT, 5, number of init entries (table index 0..NUM_INIT-1).
- NUM_POLL, 14, number of poll entries (index NUM_INIT..NUM_INIT+NUM_POLL-1); each poll entry is a single-byte read.
- STARTUP_CYCLES, 1200000, clk_12m cycles idled after reset before the first command (100 ms).
- GAP_CYCLES, 240, cycles i2c_config is held at 8'h00 between commands (≥ 2 i2c_clk periods).
- TIMEOUT_CYCLES, 120000, cycles allowed for a done edge per command.
- MAX_RETRY, 3, retries of a timed-out command before skipping it.
- FRAME_CYCLES, 120000, minimum cycles between starts of consecutive poll frames (100 Hz).

Ports:
- clk_12m, input, 1, system clock. One clock only.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, permits start of a new command when high.
- i2c_done, input, 1, completion flag from the master (i2c_clk domain, active high).
- i2c_read_data, input, 8, byte returned by the master.
- i2c_config, output, 8, mode code to the master (00 wait, 01 single write, 04 single read).
- i2c_dev_addr, output, 7, slave address.
- i2c_reg_addr, output, 8, register address.
- i2c_reg_data, output, 8, write data.
- rd_data_bus, output, 8*NUM_POLL, poll bytes; byte k is at bits [8k+7:8k].
- frame_valid, output, 1, one-cycle pulse when a poll frame completes.
- init_done, output, 1, sticky high after the last init entry finishes.
- busy, output, 1, high from ISSUE through GAP.
- timeout_err, output, 1, sticky high after any command was skipped.
- cmd_index, output, $clog2(NUM_INIT+NUM_POLL), entry currently executing.

Behaviour:
- Reset:
  - All outputs 0.
  - State STARTUP, index 0, retry count 0, counters 0.
- Done detection:
  - i2c_done passes through a 2-flop synchroniser, then rising-edge detection.
  - done_evt is valid 3 clk_12m cycles after the async edge.
- States:
  - STARTUP: count STARTUP_CYCLES → IDLE.
  - IDLE:
    - If enable is low, stay.
    - Else load entry[index] → ISSUE.
    - For poll index NUM_INIT, additionally require frame timer ≥ FRAME_CYCLES; on leaving, restart the frame timer.
  - ISSUE:
    - Drive i2c_config, i2c_dev_addr=DEV_ADDR, i2c_reg_addr, i2c_reg_data from the entry.
    - Clear the timeout counter → WAIT_DONE.
    - Outputs stay stable until GAP.
  - WAIT_DONE:
    - On done_evt: if the entry is a read, latch i2c_read_data into byte (index-NUM_INIT) of the bank in the same cycle. → GAP(ok).
    - On timeout counter = TIMEOUT_CYCLES-1 → GAP(fail).
    - If done_evt and timeout coincide, done wins.
  - GAP:
    - i2c_config=8'h00; other outputs hold.
    - Count GAP_CYCLES, then advance:
      - ok: clear retry, index+1.
      - fail with retry < MAX_RETRY: retry+1, same index.
      - fail with retry = MAX_RETRY: set timeout_err, clear retry, index+1. A skipped read leaves its old bank byte unchanged.
    - Go to IDLE.
- Index wrap:
  - After the last init entry: init_done←1.
  - After the last poll entry: index←NUM_INIT, frame_valid pulses 1 cycle on GAP exit.
  - Init is never re-run except via reset.
- enable low mid-command: the current command completes (including GAP); the sequencer then parks in IDLE.
- The frame timer saturates at FRAME_CYCLES.
- rd_data_bus updates byte-wise during the frame. Consumers sample on frame_valid.
- Async reset mid-transaction: outputs clear immediately; the master sees config 00.

Decomposition:
- Shared package i2c_seq_pkg:
  - I2C mode codes: WAIT 8'h00, SINGLE_WRITE 8'h01, CONT_WRITE 8'h02, WRITE_DIRECT 8'h03, SINGLE_READ 8'h04, CONT_READ 8'h05, READ_DIRECT 8'h06.
  - Entry layout: 24 bits = {mode[7:0], reg_addr[7:0], reg_data[7:0]}.
  - MPU6050 register constants.
- Sub-module i2c_cmd_rom: combinational case table indexed by cmd_index.
  - Init entries: 6B←00, 19←07, 1A←06, 1B←18, 1C←01.
  - Poll entries: SINGLE_READ 3B..48.
- A future device swaps only the ROM.

Test Plan:
1. Reset, then a BFM that asserts done 500 cycles after config≠0 and drops it when config=0 → first ISSUE after 1200000 cycles; config=01/reg 6B/data 00; five writes in order; init_done rises after entry 4.
2. BFM returns read_data=8'h3B+k for poll k → frame_valid pulses once per frame; rd_data_bus[7:0]=3B, [111:104]=48; consecutive frame starts are ≥120000 cycles apart.
3. BFM never asserts done for entry 2 → 4 attempts, each 120000 cycles; then timeout_err=1 and index advances to 3; no further attempts on entry 2.
4. BFM times out twice on poll 5, then succeeds → retry is transparent; byte 5 is updated; timeout_err stays 0.
5. Drop enable during WAIT_DONE of poll 3 → done is accepted, GAP completes, the sequencer parks in IDLE with config=00 and busy=0; raising enable resumes at poll 4.
6. Assert rst_n low during WAIT_DONE → all outputs 0 the same cycle; after release the sequence restarts at init entry 0.
